// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states and nibble width.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_rippleadder.sv
// 4-bit ripple-carry adder; also exposes the carry into the top bit for overflow.
module nibble_serial_add_ctrl_rippleadder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout,
    output logic                o_c_msb
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
            assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout  = w_c[NIBBLE_W];
    assign o_c_msb = w_c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder with valid/ready handshakes; one 4-bit adder reused LSB-first.
// Define SUBTRACT_EN to add the sub port (a - b via ~b and forced carry-in).
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SUBTRACT_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_carry;
    logic [W-1:0]         r_s;
    logic                 r_cout;
    logic                 r_ovf;

    logic [W-1:0]         w_b_eff;
    logic                 w_cin_eff;
    logic [NIBBLE_W-1:0]  w_a_nib;
    logic [NIBBLE_W-1:0]  w_b_nib;
    logic [NIBBLE_W-1:0]  w_sum;
    logic                 w_cout;
    logic                 w_c_msb;

`ifdef SUBTRACT_EN
    // Subtraction is a + ~b + 1, so cin is overridden rather than combined.
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    nibble_serial_add_ctrl_rippleadder u_adder (
        .i_a     (w_a_nib),
        .i_b     (w_b_nib),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_s[r_idx*NIBBLE_W +: NIBBLE_W] <= w_sum;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_cout ^ w_c_msb;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: directed corner cases plus random ops against an arithmetic model.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [31:0] a8 = '0;
    logic [31:0] b8 = '0;
    logic        cin8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [31:0] s8;
    logic        cout8;
    logic        ovf8;

`ifdef SUBTRACT_EN
    logic        sub = 1'b0;
    logic        sub8 = 1'b0;
`endif

    bit          op_sub = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUBTRACT_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    nibble_serial_add_ctrl #(.NIBBLES(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
`ifdef SUBTRACT_EN
        .sub       (sub8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .s         (s8),
        .cout      (cout8),
        .ovf       (ovf8)
    );

    // Reference: whole-word arithmetic on w bits, signed overflow from operand/result signs.
    function automatic void ref_model(input int w, input logic [31:0] ra, input logic [31:0] rb,
                                      input logic rc, input logic rs,
                                      output logic [31:0] es, output logic ec, output logic eo);
        longint unsigned mask;
        longint unsigned bb;
        longint unsigned t;
        mask = (64'd1 << w) - 64'd1;
        bb   = rs ? ((~{32'd0, rb}) & mask) : {32'd0, rb};
        t    = {32'd0, ra} + bb + (rs ? 64'd1 : {63'd0, rc});
        es   = 32'(t & mask);
        ec   = t[w];
        eo   = (ra[w-1] == bb[w-1]) && (es[w-1] != ra[w-1]);
    endfunction

    // Drives one 16-bit op; scrambles inputs and holds in_valid during RUN.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          output logic [15:0] os, output logic oc, output logic oo,
                          output int lat, output bit rdy_seen);
        a = ta; b = tb_; cin = tc;
`ifdef SUBTRACT_EN
        sub = op_sub;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef SUBTRACT_EN
            sub = 1'($urandom);
`endif
            @(posedge clk); #1;
            if (in_ready) rdy_seen = 1'b1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        os = s; oc = cout; oo = ovf;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (s !== 16'h0) $display("FAIL rst_s got=%h exp=0000", s); else n_pass++;
        n_checks++; if ({cout, ovf} !== 2'b00) $display("FAIL rst_flags got=%b%b exp=00", cout, ovf); else n_pass++;
        n_checks++; if ({in_ready8, out_valid8} !== 2'b10) $display("FAIL rst_dut8 got=%b%b exp=10", in_ready8, out_valid8); else n_pass++;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_carry_wrap();
        logic [15:0] os; logic oc, oo; int lat; bit rdy;
        op_sub = 1'b0;
        run_op(16'hFFFF, 16'h0001, 1'b0, os, oc, oo, lat, rdy);
        $display("op a=ffff b=0001 cin=0 -> s=%h cout=%b ovf=%b lat=%0d", os, oc, oo, lat);
        n_checks++; if (lat !== 4) $display("FAIL wrap_latency got=%0d exp=4", lat); else n_pass++;
        n_checks++; if (os !== 16'h0000) $display("FAIL wrap_s got=%h exp=0000", os); else n_pass++;
        n_checks++; if ({oc, oo} !== 2'b10) $display("FAIL wrap_flags got=%b%b exp=10", oc, oo); else n_pass++;
        n_checks++; if (rdy !== 1'b0) $display("FAIL wrap_ready_in_run got=%b exp=0", rdy); else n_pass++;
        finish_op();
        n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL wrap_release got=%b%b exp=10", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_signed_ovf();
        logic [15:0] os; logic oc, oo; int lat; bit rdy;
        op_sub = 1'b0;
        run_op(16'h7FFF, 16'h0001, 1'b0, os, oc, oo, lat, rdy);
        $display("op a=7fff b=0001 cin=0 -> s=%h cout=%b ovf=%b lat=%0d", os, oc, oo, lat);
        n_checks++; if (os !== 16'h8000) $display("FAIL ovf_s got=%h exp=8000", os); else n_pass++;
        n_checks++; if ({oc, oo} !== 2'b01) $display("FAIL ovf_flags got=%b%b exp=01", oc, oo); else n_pass++;
        finish_op();
    endtask

    task automatic test_random();
        logic [15:0] ta, tb_, os; logic tc, oc, oo; int lat; bit rdy;
        logic [31:0] es; logic ec, eo;
        for (int i = 0; i < 24; i++) begin
            ta = 16'($urandom); tb_ = 16'($urandom); tc = 1'($urandom);
`ifdef SUBTRACT_EN
            op_sub = 1'($urandom);
`else
            op_sub = 1'b0;
`endif
            ref_model(16, {16'd0, ta}, {16'd0, tb_}, tc, op_sub, es, ec, eo);
            run_op(ta, tb_, tc, os, oc, oo, lat, rdy);
            $display("op a=%h b=%h cin=%b sub=%b -> s=%h cout=%b ovf=%b lat=%0d", ta, tb_, tc, op_sub, os, oc, oo, lat);
            n_checks++; if (os !== es[15:0] || oc !== ec || oo !== eo)
                $display("FAIL rand_result got=%h/%b/%b exp=%h/%b/%b", os, oc, oo, es[15:0], ec, eo); else n_pass++;
            n_checks++; if (lat !== 4 || rdy !== 1'b0) $display("FAIL rand_timing got lat=%0d rdy=%b exp lat=4 rdy=0", lat, rdy); else n_pass++;
            finish_op();
        end
        op_sub = 1'b0;
    endtask

    task automatic test_done_hold();
        logic [15:0] os; logic oc, oo; int lat; bit rdy;
        logic [31:0] es; logic ec, eo;
        bit stable = 1'b1;
        op_sub = 1'b0;
        ref_model(16, 32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0, es, ec, eo);
        run_op(16'h1234, 16'h4321, 1'b1, os, oc, oo, lat, rdy);
        for (int k = 0; k < 5; k++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            if (s !== os || cout !== oc || ovf !== oo || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        $display("hold a=1234 b=4321 cin=1 -> s=%h cout=%b ovf=%b stable=%b", s, cout, ovf, stable);
        n_checks++; if (os !== es[15:0]) $display("FAIL hold_s got=%h exp=%h", os, es[15:0]); else n_pass++;
        n_checks++; if (stable !== 1'b1) $display("FAIL hold_stable got=%b exp=1", stable); else n_pass++;
        finish_op();
        n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL hold_release got=%b%b exp=10", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_reset_in_run();
        logic [15:0] os; logic oc, oo; int lat; bit rdy;
        logic [31:0] es; logic ec, eo;
        bit pulsed = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        $display("reset in RUN -> in_ready=%b out_valid=%b s=%h cout=%b ovf=%b", in_ready, out_valid, s, cout, ovf);
        n_checks++; if ({in_ready, out_valid, cout, ovf} !== 4'b1000) $display("FAIL abort_ctrl got=%b%b%b%b exp=1000", in_ready, out_valid, cout, ovf); else n_pass++;
        n_checks++; if (s !== 16'h0) $display("FAIL abort_s got=%h exp=0000", s); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) pulsed = 1'b1;
        end
        n_checks++; if (pulsed !== 1'b0) $display("FAIL abort_pulse got=%b exp=0", pulsed); else n_pass++;
        // Next op is offered straight after the edge that follows deassertion.
        @(posedge clk); #1;
        rst = 1'b1; #1; rst = 1'b0;
        op_sub = 1'b0;
        ref_model(16, 32'h0000_0F0F, 32'h0000_00F1, 1'b0, 1'b0, es, ec, eo);
        run_op(16'h0F0F, 16'h00F1, 1'b0, os, oc, oo, lat, rdy);
        $display("op after reset a=0f0f b=00f1 -> s=%h lat=%0d", os, lat);
        n_checks++; if (os !== es[15:0] || lat !== 4) $display("FAIL first_xfer got=%h/%0d exp=%h/4", os, lat, es[15:0]); else n_pass++;
        finish_op();
    endtask

`ifdef SUBTRACT_EN
    task automatic test_subtract();
        logic [15:0] os; logic oc, oo; int lat; bit rdy;
        op_sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, os, oc, oo, lat, rdy);
        $display("op a=0005 b=0007 sub=1 -> s=%h cout=%b ovf=%b", os, oc, oo);
        n_checks++; if (os !== 16'hFFFE) $display("FAIL sub_s got=%h exp=fffe", os); else n_pass++;
        n_checks++; if ({oc, oo} !== 2'b00) $display("FAIL sub_flags got=%b%b exp=00", oc, oo); else n_pass++;
        finish_op();
        op_sub = 1'b0;
    endtask
`endif

    task automatic test_nibbles8();
        int lat = -1;
        a8 = 32'h1234_5678; b8 = 32'h1111_1111; cin8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (out_valid8) begin
                lat = k;
                break;
            end
        end
        $display("op8 a=12345678 b=11111111 cin=1 -> s=%h cout=%b ovf=%b lat=%0d", s8, cout8, ovf8, lat);
        n_checks++; if (s8 !== 32'h2345_678A) $display("FAIL n8_s got=%h exp=2345678a", s8); else n_pass++;
        n_checks++; if ({cout8, ovf8} !== 2'b00) $display("FAIL n8_flags got=%b%b exp=00", cout8, ovf8); else n_pass++;
        n_checks++; if (lat !== 8) $display("FAIL n8_latency got=%0d exp=8", lat); else n_pass++;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        n_checks++; if ({in_ready8, out_valid8} !== 2'b10) $display("FAIL n8_release got=%b%b exp=10", in_ready8, out_valid8); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_signed_ovf();
        test_random();
        test_done_hold();
        test_reset_in_run();
`ifdef SUBTRACT_EN
        test_subtract();
`endif
        test_nibbles8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles; legal range is 2 to 8.
REQ-002 The block SHALL have parameter W, default 4*NIBBLES, giving the operand width in bits; it is derived and is not overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 The block SHALL have ports a and b, input, W bits each: the operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in to nibble 0.
REQ-009 The block SHALL have port sub, input, 1 bit: subtract request; it is present only when SUBTRACT_EN is defined.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port s, output, W bits: the sum or difference.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of the most significant nibble.
REQ-014 The block SHALL have port ovf, output, 1 bit: signed overflow, defined as the carry into the MSB XOR the carry out of the MSB.

Function
REQ-015 The block SHALL time-share one 4-bit ripple adder across NIBBLES cycles, processing LSB nibble first.
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; a transfer occurs when in_valid and in_ready are both high.
REQ-018 On a transfer, the block SHALL latch a, b, cin and sub, clear the nibble index to 0, and move to RUN.
REQ-019 In RUN, in_ready SHALL be 0, and each cycle the block SHALL add nibble[idx] of a and b with the carry register, write s nibble[idx], store the carry, and increment idx.
REQ-020 The carry register SHALL be loaded with the latched cin at transfer time.
REQ-021 When idx equals NIBBLES-1 in RUN, the block SHALL compute the final nibble, latch cout and ovf, and move to DONE.
REQ-022 The block SHALL assert out_valid in DONE exactly NIBBLES cycles after the transfer edge.
REQ-023 In DONE, out_valid SHALL be 1, and s, cout and ovf SHALL be held stable until out_ready is 1.
REQ-024 When out_valid and out_ready are both high, the block SHALL return to IDLE with in_ready high on the next cycle; there is no back-to-back bypass.
REQ-025 in_valid SHALL be ignored outside IDLE, and operand input changes during RUN SHALL have no effect.
REQ-026 s SHALL be updated only nibble-wise during RUN; partial values may be visible but SHALL be don't-care while out_valid is 0.
REQ-027 idx SHALL wrap to 0 only via a new transfer and SHALL never exceed NIBBLES-1.

Reset
REQ-028 Asserting rst SHALL put the block in IDLE and force in_ready to 1, out_valid, cout and ovf to 0, s to 0, idx to 0 and carry to 0.
REQ-029 Asserting rst during RUN or DONE SHALL abort the operation with no out_valid pulse.
REQ-030 The first transfer SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 When SUBTRACT_EN is defined, the sub port SHALL exist, and with sub=1 the block SHALL use ~b and force the initial carry to 1, giving a-b; cin is then ignored.
REQ-032 When SUBTRACT_EN is undefined, the sub port SHALL be absent and the block SHALL perform addition only.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant NIBBLE_W = 4.
REQ-034 The block SHALL have one natural sub-module, the existing 4-bit rippleadder, instantiated exactly once as the shared datapath.

Verification
REQ-035 The bench SHALL drive a=0xFFFF, b=0x0001, cin=0 and check s=0x0000, cout=1, ovf=0, with out_valid high at the 4th cycle after transfer.
REQ-036 The bench SHALL drive a=0x7FFF, b=0x0001, cin=0 and check s=0x8000, cout=0, ovf=1.
REQ-037 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check that s and flags stay stable, that in_ready stays 0, and that a second in_valid is not accepted.
REQ-038 The bench SHALL assert rst 2 cycles into RUN and check that all outputs match REQ-028 and that out_valid never pulses.
REQ-039 With SUBTRACT_EN defined, the bench SHALL drive a=0x0005, b=0x0007, sub=1 and check s=0xFFFE, cout=0, ovf=0.
REQ-040 With NIBBLES=8, the bench SHALL drive a=0x12345678, b=0x11111111, cin=1 and check s=0x2345678A, with latency 8 cycles.
